uart_tx_queue: RTL and testbench

Transmit-side word queue placed directly upstream of the `uart` top's TX port. It accepts 32-bit words from a producer over a valid/ready handshake and buffers them in a circular FIFO. It drains the FIFO one word at a time into `data_in`/`start`, waiting for `tx_done` before issuing the next word. The producer never has to track UART frame timing.

---
 rtl/uart_tx_queue.sv | 89 ++++++++
 tb/tb_uart_tx_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Word FIFO that feeds a UART transmitter one word per frame via a start/tx_done handshake.
// Optional `UART_TX_QUEUE_LEVEL_EN adds a `level` output mirroring the FIFO occupancy.
module uart_tx_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     start,
  input  logic                     tx_done,
  output logic                     busy,
  output logic                     empty
`ifdef UART_TX_QUEUE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             push, pop;

  assign wr_ready = (count != FULL_COUNT);
  assign empty    = (count == '0);
  // A flush cycle neither stores the incoming word nor launches a new one.
  assign push     = wr_valid && wr_ready && !flush;
  assign pop      = (state == IDLE) && !empty && !flush;
  assign start    = (state == START);
  assign busy     = (state != IDLE);

`ifdef UART_TX_QUEUE_LEVEL_EN
  assign level = count;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pop) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (tx_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      tx_data <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (pop) tx_data <= mem[rptr];
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: storage has no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: vector table plus directed multi-cycle sequences.
module tb_uart_tx_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        flush;
  logic [31:0] tx_data;
  logic        start;
  logic        tx_done;
  logic        busy;
  logic        empty;
`ifdef UART_TX_QUEUE_LEVEL_EN
  logic [3:0]  level;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_queue #(.DEPTH(8), .WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .flush    (flush),
    .tx_data  (tx_data),
    .start    (start),
    .tx_done  (tx_done),
    .busy     (busy),
    .empty    (empty)
`ifdef UART_TX_QUEUE_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wv;
    logic [31:0] wd;
    logic        fl;
    logic        td;
    logic        e_ready;
    logic        e_start;
    logic        e_busy;
    logic        e_empty;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic wv, input logic [31:0] wd, input logic fl,
                     input logic td, input logic r, input logic s, input logic b,
                     input logic e, input logic [31:0] d);
    vec_t v;
    v.name = name; v.wv = wv; v.wd = wd; v.fl = fl; v.td = td;
    v.e_ready = r; v.e_start = s; v.e_busy = b; v.e_empty = e; v.e_data = d;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic wv, input logic [31:0] wd, input logic fl, input logic td);
    wr_valid = wv; wr_data = wd; flush = fl; tx_done = td;
    @(posedge clk);
    #1;
    wr_valid = 1'b0; flush = 1'b0; tx_done = 1'b0;
  endtask

  // From WAIT: complete the current frame, then expect the next pop to carry exp.
  task automatic drain_one(input string name, input logic [31:0] exp);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    check({name, "_start"}, 32'(start), 32'd1);
    check({name, "_data"}, tx_data, exp);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int starts_seen;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; flush = 1'b0; tx_done = 1'b0;

    add("single_accept",  1, 32'hA5A5_0001, 0, 0, 1, 0, 0, 0, 32'h0);
    add("single_start",   0, 32'h0,         0, 0, 1, 1, 1, 1, 32'hA5A5_0001);
    add("single_wait0",   0, 32'h0,         0, 0, 1, 0, 1, 1, 32'hA5A5_0001);
    add("single_wait1",   0, 32'h0,         0, 0, 1, 0, 1, 1, 32'hA5A5_0001);
    add("single_done",    0, 32'h0,         0, 1, 1, 0, 0, 1, 32'hA5A5_0001);
    add("single_idle",    0, 32'h0,         0, 0, 1, 0, 0, 1, 32'hA5A5_0001);
    add("b2b_w0",         1, 32'h11,        0, 0, 1, 0, 0, 0, 32'hA5A5_0001);
    add("b2b_w1_pop",     1, 32'h22,        0, 0, 1, 1, 1, 0, 32'h11);
    add("b2b_wait",       0, 32'h0,         0, 0, 1, 0, 1, 0, 32'h11);
    add("b2b_done",       0, 32'h0,         0, 1, 1, 0, 0, 0, 32'h11);
    add("b2b_pop2",       0, 32'h0,         0, 0, 1, 1, 1, 1, 32'h22);
    add("done_in_start",  0, 32'h0,         0, 1, 1, 0, 1, 1, 32'h22);
    add("wait_after_ign", 0, 32'h0,         0, 0, 1, 0, 1, 1, 32'h22);
    add("b2b_done2",      0, 32'h0,         0, 1, 1, 0, 0, 1, 32'h22);
    add("idle_write",     1, 32'h33,        0, 0, 1, 0, 0, 0, 32'h22);
    add("idle_flush_wr",  1, 32'h44,        1, 0, 1, 0, 0, 1, 32'h22);
    add("after_flush",    0, 32'h0,         0, 0, 1, 0, 0, 1, 32'h22);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_data", tx_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].wv, vecs[i].wd, vecs[i].fl, vecs[i].td);
      check({vecs[i].name, "_ready"}, 32'(wr_ready), 32'(vecs[i].e_ready));
      check({vecs[i].name, "_start"}, 32'(start), 32'(vecs[i].e_start));
      check({vecs[i].name, "_busy"}, 32'(busy), 32'(vecs[i].e_busy));
      check({vecs[i].name, "_empty"}, 32'(empty), 32'(vecs[i].e_empty));
      check({vecs[i].name, "_data"}, tx_data, vecs[i].e_data);
    end

    // Fill to full with tx_done held low; the 10th word waits for a free slot.
    for (int i = 0; i < 9; i++) begin
      check("fill_ready", 32'(wr_ready), 32'd1);
      step(1'b1, 32'hF000_0000 + 32'(i), 1'b0, 1'b0);
    end
    check("full_ready", 32'(wr_ready), 32'd0);
    check("full_empty", 32'(empty), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hF000_0009, 1'b0, 1'b0);
      check("full_hold", 32'(wr_ready), 32'd0);
    end
    step(1'b1, 32'hF000_0009, 1'b0, 1'b1);
    check("full_done_ready", 32'(wr_ready), 32'd0);
    check("full_done_busy", 32'(busy), 32'd0);
    step(1'b1, 32'hF000_0009, 1'b0, 1'b0);
    check("full_pop_start", 32'(start), 32'd1);
    check("full_pop_data", tx_data, 32'hF000_0001);
    check("full_pop_ready", 32'(wr_ready), 32'd1);
    step(1'b1, 32'hF000_0009, 1'b0, 1'b0);
    check("full_refill", 32'(wr_ready), 32'd0);
    for (int i = 2; i < 9; i++) drain_one("full_drain", 32'hF000_0000 + 32'(i));
    drain_one("full_drain_last", 32'hF000_0009);
    check("full_drained_empty", 32'(empty), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("full_drained_busy", 32'(busy), 32'd0);

    // Stream 20 words through the queue; pointers wrap more than twice.
    fork
      begin
        int waited;
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 20 && ok; i++) begin
          wr_valid = 1'b1;
          wr_data  = 32'(i);
          waited   = 0;
          forever begin
            logic acc;
            @(negedge clk);
            acc = wr_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 200) begin
              check("stream_push_timeout", 32'd0, 32'd1);
              ok = 1'b0;
              break;
            end
          end
        end
        wr_valid = 1'b0;
      end
      begin
        int tries;
        bit ok;
        ok = 1'b1;
        for (int n = 0; n < 20 && ok; n++) begin
          tries = 0;
          forever begin
            @(negedge clk);
            if (start) break;
            tries++;
            if (tries > 100) begin
              check("stream_start_timeout", 32'd0, 32'd1);
              ok = 1'b0;
              break;
            end
          end
          if (ok) begin
            check("stream_order", tx_data, 32'(n));
            repeat (4) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
          end
        end
      end
    join
    step(1'b0, '0, 1'b0, 1'b0);
    check("stream_end_empty", 32'(empty), 32'd1);
    check("stream_end_busy", 32'(busy), 32'd0);

    // Simultaneous push and pop at a count of three.
    step(1'b1, 32'hC0, 1'b0, 1'b0);
    step(1'b1, 32'hC1, 1'b0, 1'b0);
    step(1'b1, 32'hC2, 1'b0, 1'b0);
    step(1'b1, 32'hC3, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'hC4, 1'b0, 1'b0);
    check("pushpop_start", 32'(start), 32'd1);
    check("pushpop_data", tx_data, 32'hC1);
    step(1'b0, '0, 1'b0, 1'b0);
    drain_one("pushpop_c2", 32'hC2);
    drain_one("pushpop_c3", 32'hC3);
    check("pushpop_not_empty", 32'(empty), 32'd0);
    drain_one("pushpop_c4", 32'hC4);
    check("pushpop_empty", 32'(empty), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Flush while the first word is in WAIT.
    step(1'b1, 32'hD0, 1'b0, 1'b0);
    step(1'b1, 32'hD1, 1'b0, 1'b0);
    step(1'b1, 32'hD2, 1'b0, 1'b0);
    step(1'b1, 32'hD3, 1'b0, 1'b0);
    step(1'b1, 32'hD4, 1'b0, 1'b0);
    check("flush_pre_busy", 32'(busy), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_data", tx_data, 32'hD0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    check("flush_hold_data", tx_data, 32'hD0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("flush_done_busy", 32'(busy), 32'd0);
    starts_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (start) starts_seen++;
    end
    check("flush_no_start", 32'(starts_seen), 32'd0);
    check("flush_final_empty", 32'(empty), 32'd1);

    // Asynchronous reset in WAIT with words still queued.
    step(1'b1, 32'hE0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'hE1, 1'b0, 1'b0);
    step(1'b1, 32'hE2, 1'b0, 1'b0);
    check("arst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_start", 32'(start), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_ready", 32'(wr_ready), 32'd1);
    check("arst_data", tx_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'hE5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("arst_new_start", 32'(start), 32'd1);
    check("arst_new_data", tx_data, 32'hE5);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("arst_new_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
